countdown_timer: RTL and testbench
==================================

# countdown_timer

- Loadable MM:SS BCD down-counter for the stopwatch datapath.
- Counts toward zero on each prescaler tick and supports pause and start.
- Flags expiry with a one-cycle DONE pulse and a held EXPIRED level.
- Drives the same four-digit display path as the up-counting stopwatch chain.

## Interface
- MAX_M10, default 5: maximum minutes-tens digit; also the borrow reload value for M10.
- CLK  in  1  system clock; all state changes on posedge.
- RESET  in  1  synchronous, active-high reset.
- TICK  in  1  one-cycle count enable from the 1 Hz prescaler.
- LOAD  in  1  one-cycle pulse that loads LOAD_DIGITS.
- LOAD_DIGITS  in  16  BCD digits {M10,M1,S10,S1}, 4 bits each.
- START  in  1  one-cycle pulse that begins counting.
- PAUSE  in  1  level; while high, ticks are ignored.
- DIGITS  out  16  current BCD value {M10,M1,S10,S1}.
- RUNNING  out  1  high in state RUN.
- DONE  out  1  one-cycle pulse on reaching 00:00.
- EXPIRED  out  1  high in state EXPIRED.

## Operation
- States:
  - IDLE: holding a loaded value, not counting.
  - RUN: counting on unpaused ticks.
  - PAUSED: RUN frozen by PAUSE.
  - EXPIRED: reached zero.
- Input priority per cycle: RESET > LOAD > START > PAUSE > TICK.
- LOAD, from any state:
  - Digits take LOAD_DIGITS, clamped per digit: S1, M1 >9 → 9; S10 >5 → 5; M10 >MAX_M10 → MAX_M10.
  - The clamped value is copied to the shadow register.
  - Next state is IDLE. DONE is forced 0 that cycle.
- START:
  - IDLE with DIGITS ≠ 0 → RUN.
  - IDLE with DIGITS = 0 → ignored, stay IDLE.
  - RUN, PAUSED or EXPIRED → ignored.
- PAUSE:
  - RUN with PAUSE high → PAUSED.
  - PAUSED with PAUSE low → RUN.
  - PAUSE has no effect in IDLE or EXPIRED.
- TICK in RUN with PAUSE low decrements the value:
  - S1 0→9 with borrow into S10.
  - S10 0→5 with borrow into M1.
  - M1 0→9 with borrow into M10.
  - M10 0→MAX_M10. This wrap is unreachable because zero detection happens first.
- Zero detection: a tick taken at value 00:01 produces 00:00, pulses DONE and enters EXPIRED.
- EXPIRED holds 00:00 until LOAD or RESET.
- TICK is ignored in IDLE, PAUSED and EXPIRED, and in any cycle where LOAD, START or PAUSE acts.

## Timing
- Reset values:
  - DIGITS = 16'h0000, state IDLE, shadow = 0.
  - RUNNING = 0, DONE = 0, EXPIRED = 0.
- All outputs are registered. DIGITS, RUNNING and EXPIRED update on the clock edge that samples the causing input.
- START, cycle N: RUNNING = 1 from edge N. The first decrement needs a TICK at cycle N+1 or later.
- Last tick: a TICK at 00:01 in cycle N gives DIGITS = 0, DONE = 1 and EXPIRED = 1 from edge N. DONE deasserts at edge N+1.
- DONE is never high for two consecutive cycles.
- RESET during RUN or PAUSED: the next edge gives the full reset state with no DONE pulse.
- LOAD in the same cycle as a zero-reaching TICK: LOAD wins; no DONE, state IDLE.

## Configuration
- AUTO_RELOAD_EN defined:
  - On reaching 00:00 in RUN, DIGITS reloads from the shadow register on the same edge.
  - DONE pulses and the state stays RUN. EXPIRED is never set by this path.
  - If the shadow is zero, the block enters EXPIRED as normal.
- AUTO_RELOAD_EN undefined:
  - No shadow reload logic is built.
  - Expiry always enters EXPIRED.

## Structure
- Package stopwatch_pkg holds:
  - the state enum {IDLE, RUN, PAUSED, EXPIRED};
  - BCD_W = 4;
  - the digit limit constants S1_MAX = 9, S10_MAX = 5, M1_MAX = 9.
- Sub-module bcd_down_digit, instantiated once per digit:
  - parameter MAX;
  - inputs EN and LOAD with load value;
  - outputs the digit and BORROW, which is high when EN and the digit is 0.
  - It is the down-counting mirror of the existing mod-10 counter. The top level chains each BORROW into the next EN.

## Test plan
- Reset, then LOAD 16'h0003, START, three TICKs → DIGITS 0002, 0001, 0000; DONE high exactly one cycle on the third; EXPIRED = 1; RUNNING = 0.
- LOAD 16'h1000 (10:00), START, one TICK → DIGITS = 16'h0959, covering the borrow through all four digits.
- LOAD 16'hFA7C → clamped to 16'h5959 with MAX_M10 = 5.
- In RUN, hold PAUSE high for 5 TICKs, then release → DIGITS unchanged; RUNNING low while paused and high after release.
- START on 0000 → stays IDLE; RESET asserted mid-RUN at 0042 → DIGITS = 0, no DONE.
- With AUTO_RELOAD_EN: LOAD 0002, START, 4 TICKs → 0001, 0002 (DONE), 0001, 0002 (DONE); RUNNING stays 1.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and BCD digit limits for the stopwatch datapath.
package stopwatch_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] S1_MAX  = 4'd9;
    localparam logic [BCD_W-1:0] S10_MAX = 4'd5;
    localparam logic [BCD_W-1:0] M1_MAX  = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v,
                                                   input logic [BCD_W-1:0] mx);
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer; the DUT takes the slave side.
interface countdown_timer_if;
    import stopwatch_pkg::*;

    logic                   tick;
    logic                   load;
    logic [4*BCD_W-1:0]     load_digits;
    logic                   start;
    logic                   pause;
    logic [4*BCD_W-1:0]     digits;
    logic                   running;
    logic                   done;
    logic                   expired;

    modport master (
        output tick, load, load_digits, start, pause,
        input  digits, running, done, expired
    );

    modport slave (
        input  tick, load, load_digits, start, pause,
        output digits, running, done, expired
    );

endinterface

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit that wraps 0 -> MAX and borrows into the next digit.
module bcd_down_digit
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_val,
    output logic [BCD_W-1:0] o_digit,
    output logic             o_borrow
);

    localparam logic [BCD_W-1:0] MAX_V = BCD_W'(MAX);

    logic [BCD_W-1:0] r_digit;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_digit <= '0;
        else if (i_load)
            r_digit <= i_load_val;
        else if (i_en)
            r_digit <= (r_digit == '0) ? MAX_V : r_digit - BCD_W'(1);
    end

    assign o_digit  = r_digit;
    assign o_borrow = i_en && (r_digit == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable MM:SS BCD countdown timer with pause/start and expiry flags.
// Optional AUTO_RELOAD_EN: reload from the shadow value on reaching 00:00 and keep running.
module countdown_timer
    import stopwatch_pkg::*;
#(
    parameter int MAX_M10 = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    countdown_timer_if.slave bus
);

    localparam logic [BCD_W-1:0] M10_MAX = BCD_W'(MAX_M10);

    state_t             r_state, w_nxt;
    logic               r_done, r_running, r_expired, w_done_nxt;
    logic [4*BCD_W-1:0] w_digits, w_clamped, w_ld_val;
    logic [3:0]         w_en, w_borrow;
    logic               w_dec, w_zero_hit, w_reload, w_ld;

    assign w_clamped = {bcd_clamp(bus.load_digits[15:12], M10_MAX),
                        bcd_clamp(bus.load_digits[11:8],  M1_MAX),
                        bcd_clamp(bus.load_digits[7:4],   S10_MAX),
                        bcd_clamp(bus.load_digits[3:0],   S1_MAX)};

    // START in RUN does not act, so only LOAD or PAUSE can swallow a tick here.
    assign w_dec = (r_state == RUN) && bus.tick && !bus.pause && !bus.load;
    // M10 borrow cannot occur from a nonzero value; treated as expiry defensively.
    assign w_zero_hit = w_dec && ((w_digits == 16'h0001) || w_borrow[3]);

`ifdef AUTO_RELOAD_EN
    logic [4*BCD_W-1:0] r_shadow;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_shadow <= '0;
        else if (bus.load)
            r_shadow <= w_clamped;
    end

    assign w_reload = w_zero_hit && (r_shadow != '0);
    assign w_ld_val = bus.load ? w_clamped : r_shadow;
`else
    assign w_reload = 1'b0;
    assign w_ld_val = w_clamped;
`endif

    assign w_ld = bus.load || w_reload;
    assign w_en = {w_borrow[2:0], w_dec};

    for (genvar g = 0; g < 4; g++) begin : g_dig
        localparam int DMAX = (g == 3) ? MAX_M10 : (g == 1) ? 5 : 9;
        bcd_down_digit #(.MAX(DMAX)) u_dig (
            .i_clk      (i_clk),
            .i_rst      (i_reset),
            .i_en       (w_en[g]),
            .i_load     (w_ld),
            .i_load_val (w_ld_val[g*BCD_W +: BCD_W]),
            .o_digit    (w_digits[g*BCD_W +: BCD_W]),
            .o_borrow   (w_borrow[g])
        );
    end

    always_comb begin
        w_nxt      = r_state;
        w_done_nxt = 1'b0;
        if (bus.load) begin
            w_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (bus.start && (w_digits != '0)) w_nxt = RUN;
                RUN: begin
                    if (bus.pause) begin
                        w_nxt = PAUSED;
                    end else if (w_zero_hit) begin
                        w_done_nxt = 1'b1;
                        w_nxt      = w_reload ? RUN : EXPIRED;
                    end
                end
                PAUSED:  if (!bus.pause) w_nxt = RUN;
                EXPIRED: w_nxt = EXPIRED;
                default: w_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_done    <= 1'b0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_done    <= w_done_nxt;
            r_running <= (w_nxt == RUN);
            r_expired <= (w_nxt == EXPIRED);
        end
    end

    assign bus.digits  = w_digits;
    assign bus.running = r_running;
    assign bus.done    = r_done;
    assign bus.expired = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a seconds-based model predicts every cycle's outputs.
module tb_countdown_timer;
    import stopwatch_pkg::*;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    typedef struct packed {
        logic [15:0] dig;
        logic        run;
        logic        done;
        logic        exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    countdown_timer_if bus();

    countdown_timer #(.MAX_M10(5)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_state = M_IDLE, m_secs = 0, m_shadow = 0;
    bit   m_done = 1'b0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clampd(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int m, sec;
        m   = s / 60;
        sec = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    task automatic model(input bit r, input bit t, input bit l, input logic [15:0] ld,
                         input bit s, input bit p);
        m_done = 1'b0;
        if (r) begin
            m_state = M_IDLE; m_secs = 0; m_shadow = 0;
        end else if (l) begin
            m_secs = clampd(int'(ld[15:12]), 5) * 600 + clampd(int'(ld[11:8]), 9) * 60
                   + clampd(int'(ld[7:4]), 5) * 10 + clampd(int'(ld[3:0]), 9);
            m_shadow = m_secs;
            m_state  = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE:   if (s && m_secs != 0) m_state = M_RUN;
                M_RUN: begin
                    if (p) m_state = M_PAUSED;
                    else if (t) begin
                        m_secs--;
                        if (m_secs == 0) begin
                            m_done = 1'b1;
`ifdef AUTO_RELOAD_EN
                            if (m_shadow != 0) m_secs = m_shadow;
                            else m_state = M_EXP;
`else
                            m_state = M_EXP;
`endif
                        end
                    end
                end
                M_PAUSED: if (!p) m_state = M_RUN;
                default:  m_state = M_EXP;
            endcase
        end
    endtask

    task automatic cyc(input bit r, input bit t, input bit l, input logic [15:0] ld,
                       input bit s, input bit p);
        exp_t e;
        @(negedge clk);
        rst = r; bus.tick = t; bus.load = l; bus.load_digits = ld;
        bus.start = s; bus.pause = p;
        model(r, t, l, ld, s, p);
        e.dig  = to_bcd(m_secs);
        e.run  = (m_state == M_RUN);
        e.done = m_done;
        e.exp  = (m_state == M_EXP);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("digits",  bus.digits,            e.dig);
        chk("running", {15'b0, bus.running},  {15'b0, e.run});
        chk("done",    {15'b0, bus.done},     {15'b0, e.done});
        chk("expired", {15'b0, bus.expired},  {15'b0, e.exp});
    endtask

    task automatic idle();                     cyc(0, 0, 0, 16'h0, 0, 0); endtask
    task automatic tick();                     cyc(0, 1, 0, 16'h0, 0, 0); endtask
    task automatic start();                    cyc(0, 0, 0, 16'h0, 1, 0); endtask
    task automatic load(input logic [15:0] v); cyc(0, 0, 1, v,     0, 0); endtask

    initial begin
        rst = 1'b1; bus.tick = 0; bus.load = 0; bus.load_digits = '0;
        bus.start = 0; bus.pause = 0;

        cyc(1, 0, 0, 16'h0, 0, 0);
        cyc(1, 1, 1, 16'h1234, 1, 0);
        chk("rst_digits", bus.digits, 16'h0000);
        idle();

        // Short countdown to expiry
        load(16'h0003); start();
        tick(); chk("t1_0002", bus.digits, 16'h0002);
        tick(); chk("t1_0001", bus.digits, 16'h0001);
        tick();
`ifndef AUTO_RELOAD_EN
        chk("t1_zero", bus.digits, 16'h0000);
        chk("t1_done", {15'b0, bus.done}, 16'h0001);
        chk("t1_exp",  {15'b0, bus.expired}, 16'h0001);
`endif
        idle(); chk("t1_done_low", {15'b0, bus.done}, 16'h0000);
        start(); tick(); idle();

        // Borrow ripple through all four digits
        load(16'h1000); start(); tick();
        chk("borrow_all", bus.digits, 16'h0959);

        load(16'hFA7C); chk("clamp", bus.digits, 16'h5959);

        // Pause holds value and drops RUNNING
        load(16'h0010); start(); tick();
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 16'h0, 0, 1);
        chk("paused_run", {15'b0, bus.running}, 16'h0000);
        cyc(0, 0, 0, 16'h0, 0, 0);
        chk("resume_run", {15'b0, bus.running}, 16'h0001);
        chk("paused_dig", bus.digits, 16'h0009);
        cyc(0, 1, 0, 16'h0, 1, 0);

        load(16'h0000); start();
        chk("start_zero", {15'b0, bus.running}, 16'h0000);

        load(16'h0042); start(); tick(); tick();
        cyc(1, 1, 0, 16'h0, 0, 0);
        chk("rst_run_dig",  bus.digits, 16'h0000);
        chk("rst_run_done", {15'b0, bus.done}, 16'h0000);

        // LOAD beats a zero-reaching tick
        load(16'h0001); start();
        cyc(0, 1, 1, 16'h0030, 0, 0);
        chk("load_wins_dig",  bus.digits, 16'h0030);
        chk("load_wins_done", {15'b0, bus.done}, 16'h0000);
        tick();

`ifdef AUTO_RELOAD_EN
        load(16'h0002); start();
        tick(); chk("ar_1", bus.digits, 16'h0001);
        tick(); chk("ar_2", bus.digits, 16'h0002);
        chk("ar_done", {15'b0, bus.done}, 16'h0001);
        tick(); chk("ar_3", bus.digits, 16'h0001);
        tick(); chk("ar_4", bus.digits, 16'h0002);
        chk("ar_run", {15'b0, bus.running}, 16'h0001);
`endif

        for (int i = 0; i < 400; i++) begin
            logic [15:0] v;
            v = ($urandom_range(3) == 0) ? 16'($urandom_range(15)) : 16'($urandom);
            cyc(($urandom_range(60) == 0), $urandom_range(1) == 1, ($urandom_range(15) == 0),
                v, ($urandom_range(5) == 0), ($urandom_range(6) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
